// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding and constants for the SRAM clear/load arbiter
package sram_arb_pkg;
    typedef enum logic [2:0] {IDLE, CLR_SETUP, CLR_WE, CLR_HOLD, LD_SETUP, LD_WE, LD_HOLD} state_t;
    localparam logic [7:0] SRAM_IDLE_BYTE = 8'hFF;
endpackage

// File: rtl/sram_write_seq.sv
// sram_write_seq: nWE timing of one SRAM byte write (SETUP, WR_CYCLES of WE, HOLD)
module sram_write_seq #(
    parameter int WR_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic nwe_o,
    output logic done_o
);
    localparam int CW = WR_CYCLES > 1 ? $clog2(WR_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic nwe_q, nwe_d;
    // start_i marks SETUP; nWE then stays low WR_CYCLES cycles and done_o flags the last one
    always_comb begin
        done_o = ~nwe_q & (cnt_q == '0);
        nwe_d  = start_i ? 1'b0 : done_o ? 1'b1 : nwe_q;
        cnt_d  = start_i ? CW'(WR_CYCLES - 1) : (~nwe_q & ~done_o) ? cnt_q - 1'b1 : cnt_q;
    end
    // nWE and the low-phase counter are registered so the pin never glitches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nwe_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            nwe_q <= nwe_d;
            cnt_q <= cnt_d;
        end
    end
    assign nwe_o = nwe_q;
endmodule

// File: rtl/sram_clear_arbiter.sv
// sram_clear_arbiter: shares the SRAM port between the clear engine, the HPS loader and the core
module sram_clear_arbiter
    import sram_arb_pkg::*;
#(
    parameter int         ADDR_W      = 21,
    parameter int         CLEAR_WORDS = 2**21,
    parameter logic [7:0] FILL_VALUE  = 8'hFF,
    parameter int         WR_CYCLES   = 2,
    parameter bit         CLR_ON_RST  = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              core_hold,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,
    input  logic [ADDR_W-1:0] core_a,
    input  logic [7:0]        core_dq_o,
    output logic [7:0]        core_dq_i,
    input  logic              core_nce,
    input  logic              core_noe,
    input  logic              core_nwe,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_nce,
    output logic              sram_noe,
    output logic              sram_nwe
);
    localparam state_t            RST_STATE = CLR_ON_RST ? CLR_SETUP : IDLE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d, a_q, a_d;
    logic [7:0] dq_q, dq_d;
    logic pend_q, pend_d, ack_q, ack_d, nce_q, nce_d, oe_q, oe_d;
    logic clr_go, clr_st_d, idle, seq_start, seq_done, seq_nwe;

    sram_write_seq #(.WR_CYCLES(WR_CYCLES)) u_seq (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .start_i(seq_start),
        .nwe_o  (seq_nwe),
        .done_o (seq_done)
    );

    assign idle      = state_q == IDLE;
    assign seq_start = state_q inside {CLR_SETUP, LD_SETUP};

    // next state: a pending clear beats the loader; a clear request restarts a pass at the next SETUP
    always_comb begin
        clr_go     = pend_q | clear_req;
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        pend_d     = clr_go;
        ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d    = CLR_SETUP;
                    clr_addr_d = '0;
                    pend_d     = 1'b0;
                end else if (ld_req) state_d = LD_SETUP;
            end
            CLR_SETUP: state_d = CLR_WE;
            CLR_WE:    state_d = seq_done ? CLR_HOLD : CLR_WE;
            CLR_HOLD: begin
                if (clr_go) begin
                    state_d    = CLR_SETUP;
                    clr_addr_d = '0;
                    pend_d     = 1'b0;
                end else if (clr_addr_q == LAST_ADDR) state_d = IDLE;
                else begin
                    state_d    = CLR_SETUP;
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            LD_SETUP:  state_d = LD_WE;
            LD_WE:     state_d = seq_done ? LD_HOLD : LD_WE;
            LD_HOLD: begin
                state_d = IDLE;
                ack_d   = 1'b1;
            end
            default:   state_d = IDLE;
        endcase
        clr_st_d = state_d inside {CLR_SETUP, CLR_WE, CLR_HOLD};
        a_d      = clr_st_d ? clr_addr_d : (idle && state_d == LD_SETUP) ? ld_addr : a_q;
        dq_d     = clr_st_d ? FILL_VALUE : (idle && state_d == LD_SETUP) ? ld_data : dq_q;
        nce_d    = state_d == IDLE;
        oe_d     = state_d != IDLE;
    end

    // state, clear counter and the registered write-side SRAM controls
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            a_q        <= '0;
            dq_q       <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            nce_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            a_q        <= a_d;
            dq_q       <= dq_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            nce_q      <= nce_d;
            oe_q       <= oe_d;
        end
    end

    assign clear_busy = clear_req | pend_q | (state_q inside {CLR_SETUP, CLR_WE, CLR_HOLD});
    assign core_hold  = ~idle;
    assign ld_ack     = ack_q;
    assign sram_a     = idle ? core_a : a_q;
    assign sram_dq_o  = idle ? core_dq_o : dq_q;
    assign sram_dq_oe = idle ? ~core_nwe & ~core_nce : oe_q;
    assign sram_nce   = idle ? core_nce : nce_q;
    assign sram_noe   = idle ? core_noe : 1'b1;
    assign sram_nwe   = idle ? core_nwe : seq_nwe;
    assign core_dq_i  = idle ? sram_dq_i : SRAM_IDLE_BYTE;
endmodule

// File: tb/tb_sram_clear_arbiter.sv
// tb_sram_clear_arbiter: randomized scoreboard bench for the SRAM clear/load/core arbiter
module tb_sram_clear_arbiter;
    localparam int AW = 21;
    localparam int NW = 16;
    localparam int WR = 2;
    localparam int WT = WR + 2;
    logic clk = 1'b0, reset = 1'b1, clear_req = 1'b0, ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0, core_a = '0;
    logic [7:0] ld_data = '0, core_dq_o = '0, sram_dq_i = '0;
    logic core_nce = 1'b1, core_noe = 1'b1, core_nwe = 1'b1;
    logic clear_busy, core_hold, ld_ack, sram_dq_oe, sram_nce, sram_noe, sram_nwe;
    logic [7:0] core_dq_i, sram_dq_o;
    logic [AW-1:0] sram_a;
    int total = 0, bad = 0, ffbad = 0;
    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    sram_clear_arbiter #(
        .ADDR_W(AW), .CLEAR_WORDS(NW), .FILL_VALUE(8'hFF), .WR_CYCLES(WR), .CLR_ON_RST(1'b1)
    ) dut (
        .clk_sys(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
        .core_hold(core_hold), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ack(ld_ack), .core_a(core_a), .core_dq_o(core_dq_o), .core_dq_i(core_dq_i),
        .core_nce(core_nce), .core_noe(core_noe), .core_nwe(core_nwe), .sram_a(sram_a),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_nce(sram_nce), .sram_noe(sram_noe), .sram_nwe(sram_nwe)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a clear pass writes 0xFF to every address from 0 upward
    task automatic push_pass(input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back({AW'(i), 8'hFF});
    endtask

    // one loader transaction; n = clocks from the accepting edge to the ack
    task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d, input bit scr,
                           output int n, output logic [7:0] hm);
        hm = '0;
        n = 0;
        exp_q.push_back({a, d});
        ld_addr = a;
        ld_data = d;
        ld_req = 1'b1;
        while (n < 400) begin
            tick();
            n++;
            if (n == 1) clear_req = 1'b0;
            if (n < 8) hm[n] = core_hold;
            if (core_hold && core_dq_i !== 8'hFF) ffbad++;
            if (scr && n == 1) begin
                ld_addr = AW'($urandom);
                ld_data = 8'($urandom);
            end
            if (ld_ack) break;
        end
        ld_req = 1'b0;
    endtask

    // monitor: every write cycle the arbiter drives is popped from the scoreboard
    initial begin
        logic pn;
        int len;
        wr_t w;
        pn = 1'b1;
        len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pn = 1'b1;
                len = 0;
            end else begin
                if (core_hold) begin
                    if (!sram_nwe && pn) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL wr_unexpected: got a=%0h d=%0h expected no write", sram_a, sram_dq_o);
                        end else begin
                            w = exp_q.pop_front();
                            chk("wr_addr", sram_a, w.a);
                            chk("wr_data", sram_dq_o, w.d);
                        end
                        chk("wr_ctl", {sram_nce, sram_noe, sram_dq_oe}, 3'b011);
                    end
                    if (!sram_nwe) len++;
                    else if (len != 0) begin
                        chk("we_width", len, WR);
                        len = 0;
                    end
                end
                pn = sram_nwe;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mism, acks, w;
        logic [7:0] hm;
        logic [2:0] c;
        push_pass(NW);
        repeat (2) tick();
        chk("rst_sram", {sram_nce, sram_noe, sram_nwe, sram_dq_oe, sram_a, sram_dq_o}, {4'b1110, 29'd0});
        chk("rst_ctl", {ld_ack, clear_busy, core_hold, core_dq_i}, {3'b011, 8'hFF});
        reset = 1'b0;
        n = 0;
        mism = 0;
        while (clear_busy && n < 400) begin
            tick();
            n++;
            if (core_hold !== clear_busy) mism++;
        end
        chk("clr_len", n, NW * WT);
        chk("hold_tracks_busy", mism, 0);
        chk("clr_drain", exp_q.size(), 0);
        // idle passthrough: fixed write, fixed read, then random patterns
        for (int i = 0; i < 6; i++) begin
            core_a = (i == 0) ? 21'h00123 : AW'($urandom);
            core_dq_o = (i == 0) ? 8'h5A : 8'($urandom);
            c = (i == 0) ? 3'b100 : (i == 1) ? 3'b001 : 3'($urandom);
            {core_noe, core_nce, core_nwe} = c;
            sram_dq_i = 8'($urandom);
            #1;
            chk("pt_sram", {sram_a, sram_dq_o, sram_noe, sram_nce, sram_nwe, sram_dq_oe},
                {core_a, core_dq_o, c, ~c[1] & ~c[0]});
            chk("pt_rd", core_dq_i, sram_dq_i);
            tick();
        end
        {core_noe, core_nce, core_nwe} = 3'b111;
        do_load(21'h1ABCD, 8'h3C, 1'b1, n, hm);
        chk("ld_ack_lat", n, WT + 1);
        chk("ld_hold", hm[5:1], 5'b01111);
        tick();
        chk("ld_ack_pulse", ld_ack, 1'b0);
        // random loads with random idle gaps while the core keeps toggling
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            {core_noe, core_nce, core_nwe} = 3'($urandom);
            core_a = AW'($urandom);
            core_dq_o = 8'($urandom);
            do_load(AW'($urandom), 8'($urandom), 1'b1, n, hm);
            chk("rnd_ld_lat", n, WT + 1);
            chk("rnd_ld_hold", hm[5:1], 5'b01111);
        end
        {core_noe, core_nce, core_nwe} = 3'b111;
        tick();
        // clear restarted during word w: word w finishes, then a full pass from 0
        w = $urandom_range(2, NW - 3);
        push_pass(w + 1);
        push_pass(NW);
        clear_req = 1'b1;
        #1;
        chk("busy_now", clear_busy, 1'b1);
        tick();
        n = 1;
        clear_req = 1'b0;
        repeat (4 * w + 1) begin
            tick();
            n++;
        end
        clear_req = 1'b1;
        tick();
        n++;
        clear_req = 1'b0;
        while (clear_busy && n < 2000) begin
            tick();
            n++;
        end
        chk("restart_len", n, 1 + WT * (w + 1 + NW));
        chk("restart_drain", exp_q.size(), 0);
        // clear and load requested together: full clear first, then the load
        push_pass(NW);
        clear_req = 1'b1;
        do_load(AW'($urandom), 8'($urandom), 1'b0, n, hm);
        chk("clr_then_ld", n, 1 + NW * WT + WT + 1);
        tick();
        // async reset in the middle of a loader write drops it and reruns the clear
        ld_addr = AW'($urandom);
        ld_data = 8'($urandom);
        ld_req = 1'b1;
        tick();
        tick();
        chk("pre_rst_we", {core_hold, sram_nwe}, 2'b10);
        #1;
        reset = 1'b1;
        ld_req = 1'b0;
        #1;
        chk("rst_mid", {sram_nwe, sram_dq_oe, sram_nce, ld_ack}, 4'b1010);
        push_pass(NW);
        tick();
        tick();
        reset = 1'b0;
        n = 0;
        acks = 0;
        while (clear_busy && n < 400) begin
            tick();
            n++;
            acks += ld_ack;
        end
        chk("rerun_len", n, NW * WT);
        chk("no_ack", acks, 0);
        repeat (3) tick();
        chk("final_drain", exp_q.size(), 0);
        chk("dq_i_ff_held", ffbad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
